// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller that turns simple_double_port_ram into a single-clock FIFO.
// Optional macro SYNC_FIFO_ERR_FLAG_EN adds sticky overflow_o/underflow_o ports.
module sync_fifo_ctrl #(
  parameter int RAM_DEEPTH      = 1024,
  parameter int ALMOST_FULL_TH  = RAM_DEEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic                          rd_en_i,
  output logic                          ram_wr_en_o,
  output logic [$clog2(RAM_DEEPTH)-1:0] ram_wr_addr_o,
  output logic                          ram_rd_en_o,
  output logic [$clog2(RAM_DEEPTH)-1:0] ram_rd_addr_o,
  output logic                          rd_valid_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          almost_full_o,
  output logic                          almost_empty_o,
`ifdef SYNC_FIFO_ERR_FLAG_EN
  output logic                          overflow_o,
  output logic                          underflow_o,
`endif
  output logic [$clog2(RAM_DEEPTH):0]   data_count_o
);

  localparam int AW = $clog2(RAM_DEEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(RAM_DEEPTH);
  localparam logic [AW:0] AF_TH     = (AW+1)'(ALMOST_FULL_TH);
  localparam logic [AW:0] AE_TH     = (AW+1)'(ALMOST_EMPTY_TH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        rd_valid;
  logic        wr_acc;
  logic        rd_acc;
  logic        ptr_full;

  // Handshake: a request is accepted in the cycle it is high and the matching
  // flag (full for writes, empty for reads) is low; rejected requests are dropped.
  // Requests seen while rst_i is high are never accepted.
  assign wr_acc = wr_en_i & ~full_o & ~rst_i;
  assign rd_acc = rd_en_i & ~empty_o & ~rst_i;

  assign ram_wr_en_o   = wr_acc;
  assign ram_wr_addr_o = wr_ptr[AW-1:0];
  assign ram_rd_en_o   = rd_acc;
  assign ram_rd_addr_o = rd_ptr[AW-1:0];
  assign rd_valid_o    = rd_valid;

  // Flags come from the registered count only.
  assign full_o         = (count == DEPTH_CNT);
  assign empty_o        = (count == '0);
  assign almost_full_o  = (count >= AF_TH);
  assign almost_empty_o = (count <= AE_TH);
  assign data_count_o   = count;

  assign ptr_full = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_en_i & full_o)  overflow_o  <= 1'b1;
      if (rd_en_i & empty_o) underflow_o <= 1'b1;
    end
  end
`endif

  // The wrap-bit pointer difference and the occupancy counter must agree on full.
  a_full_consistent: assert property (@(posedge clk_i) disable iff (rst_i) full_o == ptr_full);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (RAM_DEEPTH=8) with a behavioural RAM and queue model.
// Build with +define+SYNC_FIFO_ERR_FLAG_EN to also exercise the error flags.
module tb_sync_fifo_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          wr_en_i = 1'b0;
  logic          rd_en_i = 1'b0;
  logic          ram_wr_en_o;
  logic [AW-1:0] ram_wr_addr_o;
  logic          ram_rd_en_o;
  logic [AW-1:0] ram_rd_addr_o;
  logic          rd_valid_o;
  logic          full_o;
  logic          empty_o;
  logic          almost_full_o;
  logic          almost_empty_o;
  logic [AW:0]   data_count_o;
`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic          overflow_o;
  logic          underflow_o;
`endif

  sync_fifo_ctrl #(.RAM_DEEPTH(DEPTH), .ALMOST_FULL_TH(DEPTH-2), .ALMOST_EMPTY_TH(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .rd_en_i(rd_en_i),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o),
    .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o),
    .rd_valid_o(rd_valid_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
`ifdef SYNC_FIFO_ERR_FLAG_EN
    .overflow_o(overflow_o), .underflow_o(underflow_o),
`endif
    .data_count_o(data_count_o)
  );

  always #5 clk = ~clk;

  // Stand-in for simple_double_port_ram: registered read, contents survive reset.
  logic [7:0] wr_data;
  logic [7:0] mem [DEPTH];
  logic [7:0] ram_rd_data;
  always @(posedge clk) begin
    if (ram_wr_en_o) mem[ram_wr_addr_o] <= wr_data;
    if (ram_rd_en_o) ram_rd_data <= mem[ram_rd_addr_o];
  end

  // Reference model state
  logic [7:0] exp_q[$];
  int         wr_total, rd_total;
  logic       exp_wacc, exp_racc, exp_rd_valid;
  logic [7:0] exp_rd_data;
  logic       exp_ovf, exp_unf;
  logic       obs_wr_en, obs_rd_en;
  logic [AW-1:0] obs_wr_addr, obs_rd_addr;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [3:0] exp_flags();
    int n = exp_q.size();
    return {n == DEPTH, n == 0, n >= DEPTH-2, n <= 2};
  endfunction

  function automatic logic [AW-1:0] waddr();
    return AW'(wr_total % DEPTH);
  endfunction

  function automatic logic [AW-1:0] raddr();
    return AW'(rd_total % DEPTH);
  endfunction

  // Drives one cycle, samples the combinational RAM controls, advances the model.
  task automatic drive_cycle(input logic wr, input logic rd, input logic [7:0] d, input logic r);
    @(negedge clk);
    wr_en_i = wr; rd_en_i = rd; wr_data = d; rst_i = r;
    exp_wacc = wr && !r && (exp_q.size() < DEPTH);
    exp_racc = rd && !r && (exp_q.size() > 0);
    #1;
    obs_wr_en = ram_wr_en_o; obs_rd_en = ram_rd_en_o;
    obs_wr_addr = ram_wr_addr_o; obs_rd_addr = ram_rd_addr_o;
    @(posedge clk);
    if (r) begin
      exp_q.delete(); wr_total = 0; rd_total = 0;
      exp_rd_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      if (wr && exp_q.size() == DEPTH) exp_ovf = 1'b1;
      if (rd && exp_q.size() == 0) exp_unf = 1'b1;
      exp_rd_valid = exp_racc;
      if (exp_racc) begin exp_rd_data = exp_q.pop_front(); rd_total++; end
      if (exp_wacc) begin exp_q.push_back(d); wr_total++; end
    end
    #1;
    wr_en_i = 1'b0; rd_en_i = 1'b0; rst_i = 1'b0;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 8'h00, 1'b1);
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (data_count_o !== 4'd0 || {full_o, empty_o, almost_full_o, almost_empty_o} !== 4'b0101
        || rd_valid_o !== 1'b0 || ram_rd_addr_o !== 3'd0 || ram_wr_addr_o !== 3'd0) begin
      errors++;
      $display("FAIL reset: count=%0d flags(f,e,af,ae)=%b rd_valid=%b rd_addr=%0d wr_addr=%0d required count=0 flags=0101 rd_valid=0 addrs=0",
               data_count_o, {full_o, empty_o, almost_full_o, almost_empty_o}, rd_valid_o, ram_rd_addr_o, ram_wr_addr_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
      checks++;
      if (obs_wr_en !== 1'b1 || obs_wr_addr !== AW'(i) || data_count_o !== 4'(i+1)
          || almost_full_o !== (i+1 >= 6) || full_o !== (i == DEPTH-1)) begin
        errors++;
        $display("FAIL fill[%0d]: wr_en=%b addr=%0d count=%0d af=%b full=%b required wr_en=1 addr=%0d count=%0d af=%b full=%b",
                 i, obs_wr_en, obs_wr_addr, data_count_o, almost_full_o, full_o, i, i+1, (i+1 >= 6), (i == DEPTH-1));
      end
    end
    drive_cycle(1'b1, 1'b0, 8'hEE, 1'b0);
    checks++;
    if (obs_wr_en !== 1'b0 || data_count_o !== 4'd8 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL fill_overflow: wr_en=%b count=%0d full=%b required wr_en=0 count=8 full=1",
               obs_wr_en, data_count_o, full_o);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (obs_rd_en !== 1'b1 || rd_valid_o !== 1'b1 || ram_rd_data !== 8'h10 + 8'(i)
          || data_count_o !== 4'(DEPTH-1-i) || empty_o !== (i == DEPTH-1)) begin
        errors++;
        $display("FAIL drain[%0d]: rd_en=%b rd_valid=%b data=%h count=%0d empty=%b required rd_en=1 rd_valid=1 data=%h count=%0d empty=%b",
                 i, obs_rd_en, rd_valid_o, ram_rd_data, data_count_o, empty_o, 8'h10 + 8'(i), DEPTH-1-i, (i == DEPTH-1));
      end
    end
    drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (obs_rd_en !== 1'b0 || rd_valid_o !== 1'b0 || data_count_o !== 4'd0) begin
      errors++;
      $display("FAIL drain_underflow: rd_en=%b rd_valid=%b count=%0d required rd_en=0 rd_valid=0 count=0",
               obs_rd_en, rd_valid_o, data_count_o);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [AW-1:0] ra;
      ra = raddr();
      drive_cycle(1'b1, 1'b1, 8'h30 + 8'(i), 1'b0);
      checks++;
      if (data_count_o !== 4'd4 || obs_rd_addr !== ra || rd_valid_o !== 1'b1 || ram_rd_data !== exp_rd_data) begin
        errors++;
        $display("FAIL simul[%0d]: count=%0d rd_addr=%0d rd_valid=%b data=%h required count=4 rd_addr=%0d rd_valid=1 data=%h",
                 i, data_count_o, obs_rd_addr, rd_valid_o, ram_rd_data, ra, exp_rd_data);
      end
    end
  endtask

  task automatic test_full_empty_simul();
    while (exp_q.size() < DEPTH) drive_cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    drive_cycle(1'b1, 1'b1, 8'hAA, 1'b0);
    checks++;
    if (obs_wr_en !== 1'b0 || obs_rd_en !== 1'b1 || data_count_o !== 4'd7 || ram_rd_data !== exp_rd_data) begin
      errors++;
      $display("FAIL full_simul: wr_en=%b rd_en=%b count=%0d data=%h required wr_en=0 rd_en=1 count=7 data=%h",
               obs_wr_en, obs_rd_en, data_count_o, ram_rd_data, exp_rd_data);
    end
    while (exp_q.size() > 0) drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    drive_cycle(1'b1, 1'b1, 8'h55, 1'b0);
    checks++;
    if (obs_wr_en !== 1'b1 || obs_rd_en !== 1'b0 || data_count_o !== 4'd1 || rd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL empty_simul: wr_en=%b rd_en=%b count=%0d rd_valid=%b required wr_en=1 rd_en=0 count=1 rd_valid=0",
               obs_wr_en, obs_rd_en, data_count_o, rd_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    while (exp_q.size() < 5) drive_cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    drive_cycle(1'b1, 1'b0, 8'h77, 1'b1);
    checks++;
    if (data_count_o !== 4'd0 || empty_o !== 1'b1 || rd_valid_o !== 1'b0
        || ram_rd_addr_o !== 3'd0 || ram_wr_addr_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d empty=%b rd_valid=%b rd_addr=%0d wr_addr=%0d required count=0 empty=1 rd_valid=0 addrs=0",
               data_count_o, empty_o, rd_valid_o, ram_rd_addr_o, ram_wr_addr_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa, ra;
      int bias;
      bias = (i < 200) ? 70 : 30;
      wa = waddr(); ra = raddr();
      drive_cycle($urandom_range(0, 99) < bias, $urandom_range(0, 99) < 100 - bias, 8'($urandom), 1'b0);
      checks++;
      if (obs_wr_en !== exp_wacc || obs_rd_en !== exp_racc || (exp_wacc && obs_wr_addr !== wa)
          || obs_rd_addr !== ra || data_count_o !== 4'(exp_q.size())
          || {full_o, empty_o, almost_full_o, almost_empty_o} !== exp_flags()
          || rd_valid_o !== exp_rd_valid || (exp_rd_valid && ram_rd_data !== exp_rd_data)) begin
        errors++;
        $display("FAIL random[%0d]: wr_en=%b rd_en=%b wa=%0d ra=%0d count=%0d flags=%b rv=%b data=%h required wr_en=%b rd_en=%b wa=%0d ra=%0d count=%0d flags=%b rv=%b data=%h",
                 i, obs_wr_en, obs_rd_en, obs_wr_addr, obs_rd_addr, data_count_o,
                 {full_o, empty_o, almost_full_o, almost_empty_o}, rd_valid_o, ram_rd_data,
                 exp_wacc, exp_racc, wa, ra, exp_q.size(), exp_flags(), exp_rd_valid, exp_rd_data);
      end
    end
  endtask

`ifdef SYNC_FIFO_ERR_FLAG_EN
  task automatic test_err_flags();
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    while (exp_q.size() < DEPTH) drive_cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_idle: overflow=%b required 0", overflow_o);
    end
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (overflow_o !== exp_ovf || exp_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b required 1", overflow_o);
    end
    while (exp_q.size() > 0) drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (underflow_o !== 1'b1 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL unf_set: underflow=%b overflow=%b required 1 1", underflow_o, overflow_o);
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (underflow_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: underflow=%b overflow=%b required 0 0", underflow_o, overflow_o);
    end
  endtask
`endif

  initial begin
    wr_data = 8'h00;
    exp_rd_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    wr_total = 0; rd_total = 0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_empty_simul();
    test_reset_mid();
    test_random();
`ifdef SYNC_FIFO_ERR_FLAG_EN
    test_err_flags();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
